program_loader: RTL and testbench
=================================

# program_loader

Upstream feeder for the CPU's instruction-cache write port. Takes a byte stream from a UART receiver, frames it into 16-bit instruction halfwords, and drives the `write` / `write_instruction_index` / `write_instruction` inputs of the CPU. It holds the CPU frozen for the whole load, because `write` high gates the CPU's internal clock. It also reports load completion and framing or timeout errors.

## Interface
Parameters:
- `SYNC_BYTE`, default 8'hA5: start-of-frame marker.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle clocks between bytes inside a frame; must be ≥ 2.

Ports:
- `clk` input, 1 bit: system clock; the CPU uses the same clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `rx_valid` input, 1 bit: one-cycle strobe; `rx_data` is valid on this cycle. Back-to-back strobes are allowed.
- `rx_data` input, 8 bits: received byte.
- `write` output, 1 bit: ICache write enable and CPU freeze.
- `write_instruction_index` output, 8 bits: ICache word index.
- `write_instruction` output, 16 bits: halfword to store. The first byte received goes in [15:8], the second in [7:0]; this is raw memory order, and the CPU's byte inverter handles endianness.
- `busy` output, 1 bit: high when the FSM is in COUNT, HI, LO, CSUM or FLUSH.
- `done` output, 1 bit: one-cycle pulse when a load completes.
- `error` output, 1 bit: high while the FSM is in ERROR.

## Operation
Frame format: `SYNC_BYTE`, then count N (N = 0 means 256 halfwords), then 2N payload bytes, then, only with the Configuration macro, one checksum byte.

States: IDLE, COUNT, HI, LO, CSUM, FLUSH, ERROR.

- **IDLE:** `write`=0. A byte equal to `SYNC_BYTE` → COUNT. Any other byte is ignored.
- **COUNT:** the byte is loaded into a 9-bit `remaining` register, with 0 mapped to 256. Word pointer is cleared to 0 and the checksum accumulator to 0. Go to HI.
- **HI:** the byte is latched into `hi_reg`. Go to LO.
- **LO:** on the byte:
  - `write_instruction` ← {`hi_reg`, byte}.
  - `write_instruction_index` ← word pointer.
  - Word pointer increments, 8-bit, wrapping 255→0; `remaining` decrements.
  - If `remaining` was 1, go to CSUM (macro defined) or FLUSH. Otherwise go to HI.
- **CSUM:** the byte is compared with the XOR of all 2N payload bytes. Match → FLUSH; mismatch → ERROR.
- **FLUSH:** lasts exactly one cycle with `write`=1, so the last word is captured. Then → IDLE, with `done`=1 on that transition.
- **ERROR:** `write` stays 1 and the CPU stays frozen. A `SYNC_BYTE` → COUNT (restart the load). Other bytes are ignored. Only reset or a new frame exits ERROR.

`write` is 1 in every state except IDLE. Between word updates the ICache rewrites the same index and data, which is harmless.

Timeout: a counter clears on every `rx_valid` and on entry to COUNT, and counts while in COUNT, HI, LO or CSUM. After `TIMEOUT_CYCLES` clocks with no strobe, → ERROR.

Payload bytes are never compared against `SYNC_BYTE`.

## Timing
- Reset values:
  - `write`=0, `write_instruction_index`=0, `write_instruction`=0.
  - `busy`=0, `done`=0, `error`=0.
  - State = IDLE, all counters 0.
- Reset mid-load: `write` drops asynchronously and the CPU resumes on the next clock. Partially written ICache contents remain.
- All outputs are registered.
- `write` rises on the clock edge that samples the `SYNC_BYTE` strobe.
- `write_instruction` and `write_instruction_index` update on the edge that samples the LO byte. The ICache captures them on the following edge.
- `write` falls, and `done` pulses, 2 cycles after the last payload byte (no macro) or after the checksum byte (macro defined).
- Minimum frame latency from `SYNC_BYTE` to `done` is 2N+3 clocks without the macro and 2N+4 clocks with it, at one byte per cycle.
- `rx_valid` with `reset` high is ignored.

## Configuration
- **`LOADER_CHECKSUM_EN` defined:** the CSUM state and the XOR accumulator exist. Every frame carries a trailing checksum byte, and a mismatch → ERROR.
- **Not defined:** CSUM is absent. LO goes straight to FLUSH after the last word, and `error` is asserted only on timeout.

## Test plan
- **Reset:** assert `reset` mid-frame → all outputs 0 immediately. After release, the byte stream 00,FF,12 causes no `write` and no `busy`.
- **Basic load (no macro):** A5,02,12,34,56,78 back-to-back → ICache writes index 0 = 16'h1234 and index 1 = 16'h5678. `write` is high from the A5 edge until 2 cycles after byte 78; `done` pulses once.
- **Count 0:** A5,00 followed by 512 bytes, each equal to its word number's low byte → 256 words written, the last at index 255, then `done`.
- **Timeout:** A5,01,12 followed by silence → `error`=1 and `write`=1 exactly `TIMEOUT_CYCLES` clocks after byte 12. A following A5,01,AB,CD → index 0 = 16'hABCD, then `done`, and `error` returns to 0.
- **Checksum (`LOADER_CHECKSUM_EN`):** A5,01,12,34,26 → `done`. A5,01,12,34,27 → `error`=1 and `write` stays 1.
- **Sync byte in payload:** A5,01,A5,A5 → index 0 = 16'hA5A5, and no restart occurs.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: frames a UART byte stream into 16-bit ICache writes and holds the CPU frozen while loading.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        write,
    output logic [7:0]  write_instruction_index,
    output logic [15:0] write_instruction,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_CSUM,
        S_FLUSH,
        S_ERROR
    } state_t;

    state_t           r_state;
    logic [8:0]       r_remaining;
    logic [7:0]       r_ptr;
    logic [7:0]       r_hi;
    logic [TMR_W-1:0] r_timer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       r_csum;
`endif

    logic w_timing;
    logic w_sync;
    logic w_timeout;

    // Inter-byte timer only runs while a frame is being received
    assign w_timing  = (r_state == S_COUNT) || (r_state == S_HI) ||
                       (r_state == S_LO)    || (r_state == S_CSUM);
    assign w_sync    = rx_valid && (rx_data == SYNC_BYTE);
    assign w_timeout = w_timing && !rx_valid && (r_timer == TMR_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state                 <= S_IDLE;
            r_remaining             <= '0;
            r_ptr                   <= '0;
            r_hi                    <= '0;
            r_timer                 <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum                  <= '0;
`endif
            write                   <= 1'b0;
            write_instruction_index <= '0;
            write_instruction       <= '0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            error                   <= 1'b0;
        end else begin
            done <= 1'b0;

            if (rx_valid) begin
                r_timer <= '0;
            end else if (w_timing) begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if (w_timeout) begin
                r_state <= S_ERROR;
                busy    <= 1'b0;
                error   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_sync) begin
                            r_state <= S_COUNT;
                            write   <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    S_COUNT: begin
                        if (rx_valid) begin
                            r_remaining <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                            r_ptr       <= '0;
`ifdef LOADER_CHECKSUM_EN
                            r_csum      <= '0;
`endif
                            r_state     <= S_HI;
                        end
                    end
                    S_HI: begin
                        if (rx_valid) begin
                            r_hi    <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                            r_csum  <= r_csum ^ rx_data;
`endif
                            r_state <= S_LO;
                        end
                    end
                    S_LO: begin
                        if (rx_valid) begin
                            write_instruction       <= {r_hi, rx_data};
                            write_instruction_index <= r_ptr;
                            r_ptr                   <= r_ptr + 8'd1;
                            r_remaining             <= r_remaining - 9'd1;
`ifdef LOADER_CHECKSUM_EN
                            r_csum                  <= r_csum ^ rx_data;
                            r_state                 <= (r_remaining == 9'd1) ? S_CSUM : S_HI;
`else
                            r_state                 <= (r_remaining == 9'd1) ? S_FLUSH : S_HI;
`endif
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (rx_valid) begin
                            if (rx_data == r_csum) begin
                                r_state <= S_FLUSH;
                            end else begin
                                r_state <= S_ERROR;
                                busy    <= 1'b0;
                                error   <= 1'b1;
                            end
                        end
                    end
`endif
                    // One extra write cycle lets the ICache capture the final word
                    S_FLUSH: begin
                        r_state <= S_IDLE;
                        write   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                    S_ERROR: begin
                        if (w_sync) begin
                            r_state <= S_COUNT;
                            busy    <= 1'b1;
                            error   <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        write   <= 1'b0;
                        busy    <= 1'b0;
                        error   <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed vector table, cycle-exact corner sequences,
// and random frames checked against a frame-level ICache model.
module tb_program_loader;
    localparam int unsigned T    = 20;
    localparam logic [7:0]  SYNC = 8'hA5;

    typedef logic [7:0] byte_q_t[$];
    typedef logic [15:0] word_q_t[$];

    typedef struct {
        logic [7:0]  lead;
        int unsigned n;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] exp_last;
        logic [7:0]  exp_idx;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        write;
    logic [7:0]  write_instruction_index;
    logic [15:0] write_instruction;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    program_loader #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(T)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .rx_valid                (rx_valid),
        .rx_data                 (rx_data),
        .write                   (write),
        .write_instruction_index (write_instruction_index),
        .write_instruction       (write_instruction),
        .busy                    (busy),
        .done                    (done),
        .error                   (error)
    );

    int n_checks = 0;
    int n_err    = 0;

    // ICache emulation driven by the DUT, plus event counters
    logic [15:0] icache [256];
    logic [15:0] model  [256];
    logic        clr_req;
    int          done_cnt  = 0;
    int          write_cyc = 0;
    int          busy_cyc  = 0;

    always @(posedge clk) begin
        if (clr_req) begin
            for (int i = 0; i < 256; i++) icache[i] <= '0;
        end else if (write) begin
            icache[write_instruction_index] <= write_instruction;
        end
        if (done)  done_cnt  <= done_cnt + 1;
        if (write) write_cyc <= write_cyc + 1;
        if (busy)  busy_cyc  <= busy_cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        @(negedge clk);
        rx_valid = v;
        rx_data  = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic send(input byte_q_t q);
        foreach (q[i]) step(1'b1, q[i]);
    endtask

    function automatic byte_q_t make_frame(input logic [7:0] n, input word_q_t w);
        byte_q_t q;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        q.push_back(SYNC);
        q.push_back(n);
        foreach (w[i]) begin
            q.push_back(w[i][15:8]);
            q.push_back(w[i][7:0]);
`ifdef LOADER_CHECKSUM_EN
            x = x ^ w[i][15:8] ^ w[i][7:0];
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        q.push_back(x);
`endif
        return q;
    endfunction

    function automatic int mem_diff();
        int d;
        d = 0;
        for (int i = 0; i < 256; i++) if (icache[i] !== model[i]) d++;
        return d;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[4];
        word_q_t     w;
        byte_q_t     q;
        int          d0, wc0, bc0, n, k, cw, junk;
        logic [7:0]  b;
        logic        cut;

        vecs[0] = '{8'h00, 2, 16'h1234, 16'h5678, 16'h5678, 8'd1};
        vecs[1] = '{8'hFF, 1, 16'hA5A5, 16'h0000, 16'hA5A5, 8'd0};
        vecs[2] = '{8'h5A, 2, 16'hA5A5, 16'hA501, 16'hA501, 8'd1};
        vecs[3] = '{8'h12, 1, 16'h0000, 16'h0000, 16'h0000, 8'd0};

        for (int i = 0; i < 256; i++) model[i] = '0;
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; clr_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_write", 32'(write), 0);
        chk("rst_index", 32'(write_instruction_index), 0);
        chk("rst_instr", 32'(write_instruction), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_error", 32'(error), 0);
        reset = 1'b0; clr_req = 1'b0;

        // Non-sync bytes in IDLE are ignored
        wc0 = write_cyc; bc0 = busy_cyc;
        q = '{8'h00, 8'hFF, 8'h12};
        send(q); idle(3);
        chk("ignore_write", 32'(write_cyc - wc0), 0);
        chk("ignore_busy",  32'(busy_cyc - bc0), 0);

        // Basic load with cycle-exact write/done timing
        d0 = done_cnt;
        w = '{16'h1234, 16'h5678};
        q = make_frame(8'd2, w);
        for (int i = 0; i < q.size(); i++) begin
            step(1'b1, q[i]);
            if (i == 1) begin
                chk("basic_write_rise", 32'(write), 1);
                chk("basic_busy_rise",  32'(busy), 1);
            end
        end
        step(1'b0, 8'h00);
        chk("basic_write_hold", 32'(write), 1);
        chk("basic_done_early", 32'(done), 0);
        chk("basic_instr", 32'(write_instruction), 32'h5678);
        chk("basic_index", 32'(write_instruction_index), 1);
        step(1'b0, 8'h00);
        chk("basic_done_pulse", 32'(done), 1);
        chk("basic_write_fall", 32'(write), 0);
        chk("basic_busy_fall",  32'(busy), 0);
        step(1'b0, 8'h00);
        chk("basic_done_once", 32'(done), 0);
        chk("basic_mem0", 32'(icache[0]), 32'h1234);
        chk("basic_mem1", 32'(icache[1]), 32'h5678);
        chk("basic_done_cnt", 32'(done_cnt - d0), 1);

        // Directed vector table
        for (int v = 0; v < 4; v++) begin
            d0 = done_cnt;
            w.delete();
            w.push_back(vecs[v].w0);
            if (vecs[v].n == 2) w.push_back(vecs[v].w1);
            q = make_frame(8'(vecs[v].n), w);
            step(1'b1, vecs[v].lead);
            send(q);
            idle(4);
            chk($sformatf("vec%0d_instr", v), 32'(write_instruction), 32'(vecs[v].exp_last));
            chk($sformatf("vec%0d_index", v), 32'(write_instruction_index), 32'(vecs[v].exp_idx));
            chk($sformatf("vec%0d_mem", v), 32'(icache[vecs[v].exp_idx]), 32'(vecs[v].exp_last));
            chk($sformatf("vec%0d_done", v), 32'(done_cnt - d0), 1);
            chk($sformatf("vec%0d_write", v), 32'(write), 0);
        end

        // Count 0 means 256 words
        d0 = done_cnt;
        w.delete();
        for (int i = 0; i < 256; i++) w.push_back({8'(i), 8'(i)});
        q = make_frame(8'd0, w);
        send(q);
        idle(4);
        for (int i = 0; i < 256; i++) model[i] = {8'(i), 8'(i)};
        chk("cnt0_index", 32'(write_instruction_index), 255);
        chk("cnt0_instr", 32'(write_instruction), 32'hFFFF);
        chk("cnt0_mem",   32'(mem_diff()), 0);
        chk("cnt0_done",  32'(done_cnt - d0), 1);

        // Timeout after a partial frame, then recovery
        step(1'b1, SYNC); step(1'b1, 8'h01); step(1'b1, 8'h12);
        idle(T);
        chk("tmo_not_yet", 32'(error), 0);
        idle(1);
        chk("tmo_error", 32'(error), 1);
        chk("tmo_write", 32'(write), 1);
        chk("tmo_busy",  32'(busy), 0);
        d0 = done_cnt;
        w = '{16'hABCD};
        q = make_frame(8'd1, w);
        send(q);
        idle(4);
        chk("tmo_rec_mem",   32'(icache[0]), 32'hABCD);
        chk("tmo_rec_done",  32'(done_cnt - d0), 1);
        chk("tmo_rec_error", 32'(error), 0);
        chk("tmo_rec_write", 32'(write), 0);

`ifdef LOADER_CHECKSUM_EN
        d0 = done_cnt;
        q = '{SYNC, 8'h01, 8'h12, 8'h34, 8'h26};
        send(q); idle(4);
        chk("csum_ok_done",  32'(done_cnt - d0), 1);
        chk("csum_ok_error", 32'(error), 0);
        d0 = done_cnt;
        q = '{SYNC, 8'h01, 8'h12, 8'h34, 8'h27};
        send(q); idle(T + 4);
        chk("csum_bad_error", 32'(error), 1);
        chk("csum_bad_write", 32'(write), 1);
        chk("csum_bad_done",  32'(done_cnt - d0), 0);
`endif

        // Asynchronous reset in the middle of a frame
        step(1'b1, SYNC); step(1'b1, 8'h02); step(1'b1, 8'h11);
        #2 reset = 1'b1;
        #1;
        chk("amid_write", 32'(write), 0);
        chk("amid_busy",  32'(busy), 0);
        chk("amid_index", 32'(write_instruction_index), 0);
        chk("amid_instr", 32'(write_instruction), 0);
        step(1'b1, SYNC);
        step(1'b0, 8'h00);
        reset = 1'b0;
        idle(2);
        chk("amid_post_write", 32'(write), 0);
        chk("amid_post_busy",  32'(busy), 0);

        // Random frames against the frame-level model
        clr_req = 1'b1; idle(1); clr_req = 1'b0; idle(1);
        for (int i = 0; i < 256; i++) model[i] = '0;
        for (int f = 0; f < 40; f++) begin
            n = int'($urandom_range(6, 1));
            w.delete();
            for (int i = 0; i < n; i++) w.push_back(16'($urandom()));
            junk = int'($urandom_range(2, 0));
            for (int j = 0; j < junk; j++) begin
                b = 8'($urandom_range(255, 0));
                if (b == SYNC) b = 8'h00;
                step(1'b1, b);
                idle(int'($urandom_range(2, 0)));
            end
            q = make_frame(8'(n), w);
            cut = ($urandom_range(5, 0) == 0);
            k = cut ? int'($urandom_range(q.size() - 1, 1)) : q.size();
            d0 = done_cnt;
            for (int i = 0; i < k; i++) begin
                step(1'b1, q[i]);
                idle(int'($urandom_range(3, 0)));
            end
            idle(cut ? T + 3 : 4);
            cw = n;
            if (cut) begin
                cw = (k >= 2) ? (k - 2) / 2 : 0;
                if (cw > n) cw = n;
            end
            for (int i = 0; i < cw; i++) model[i] = w[i];
            chk($sformatf("rnd%0d_error", f), 32'(error), 32'(cut));
            chk($sformatf("rnd%0d_write", f), 32'(write), 32'(cut));
            chk($sformatf("rnd%0d_busy", f),  32'(busy), 0);
            chk($sformatf("rnd%0d_done", f),  32'(done_cnt - d0), cut ? 0 : 1);
            chk($sformatf("rnd%0d_mem", f),   32'(mem_diff()), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
